// File: rtl/lfsr_16_checker.sv
// Receive-side checker for the 16-bit LFSR pattern stream: self-seeds, locks, then flywheels and counts errors.
// Optional LFSR16_CHK_BITERR_EN: error counter accumulates bit errors (popcount) instead of word errors.
module lfsr_16_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [15:0]      data_in,
  input  logic             clear_in,
  output logic             locked_out,
  output logic             error_out,
  output logic [ERR_W-1:0] err_count_out,
  output logic [15:0]      expected_out
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t        state;
  logic [15:0]   pred;
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;

  logic          hit, data_nz, last_match, last_miss, miss_word;
  logic [4:0]    err_inc;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14] ^ q[15], q[13:2], q[1] ^ q[15], q[0], q[15]};
  endfunction

  assign expected_out = pred;
  assign hit          = (data_in == pred);
  assign data_nz      = |data_in;
  assign last_match   = (32'(match_cnt) + 1 == LOCK_COUNT);
  assign last_miss    = (32'(miss_cnt) + 1 == LOSS_COUNT);
  assign miss_word    = valid_in && (state == LOCKED) && !hit;

`ifdef LFSR16_CHK_BITERR_EN
  logic [15:0] diff;
  assign diff = data_in ^ pred;
  always_comb begin
    err_inc = '0;
    for (int i = 0; i < 16; i++) err_inc = err_inc + {4'b0, diff[i]};
  end
`else
  assign err_inc = 5'd1;
`endif

  // One extra bit of headroom catches overflow for saturation.
  assign err_sum  = {1'b0, err_count_out} + (ERR_W + 1)'(err_inc);
  assign err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= SEARCH;
      pred          <= '0;
      match_cnt     <= '0;
      miss_cnt      <= '0;
      locked_out    <= 1'b0;
      error_out     <= 1'b0;
      err_count_out <= '0;
    end else begin
      error_out <= miss_word;
      if (clear_in)       err_count_out <= '0;
      else if (miss_word) err_count_out <= err_next;

      if (valid_in) begin
        unique case (state)
          SEARCH: if (data_nz) begin
            pred      <= lfsr_step(data_in);
            match_cnt <= '0;
            state     <= VERIFY;
          end
          VERIFY: begin
            if (hit) begin
              pred      <= lfsr_step(data_in);
              match_cnt <= match_cnt + 1'b1;
              if (last_match) begin
                state      <= LOCKED;
                locked_out <= 1'b1;
                miss_cnt   <= '0;
              end
            end else if (data_nz) begin
              pred      <= lfsr_step(data_in);
              match_cnt <= '0;
            end else begin
              state <= SEARCH;
            end
          end
          LOCKED: begin
            // Flywheel: prediction advances from itself, never from data.
            pred <= lfsr_step(pred);
            if (hit) miss_cnt <= '0;
            else if (last_miss) begin
              state      <= SEARCH;
              locked_out <= 1'b0;
              miss_cnt   <= '0;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          default: begin
            state      <= SEARCH;
            locked_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_16_checker.sv
// Scoreboard bench for lfsr_16_checker: two configurations share one stimulus stream, each with its own model.
module tb_lfsr_16_checker;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        clear_in = 1'b0;

  logic        locked_a, error_a, locked_b, error_b;
  logic [15:0] cnt_a, exp_a, exp_b;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  lfsr_16_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .data_in(data_in),
    .clear_in(clear_in), .locked_out(locked_a), .error_out(error_a),
    .err_count_out(cnt_a), .expected_out(exp_a));

  lfsr_16_checker #(.LOCK_COUNT(4), .LOSS_COUNT(31), .ERR_W(4)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .data_in(data_in),
    .clear_in(clear_in), .locked_out(locked_b), .error_out(error_b),
    .err_count_out(cnt_b), .expected_out(exp_b));

  typedef struct {
    int          mode;   // 0 search, 1 verify, 2 locked
    logic [15:0] pred;
    int          hits;
    int          misses;
    int          cnt;
    bit          err;
  } mdl_t;

  typedef struct {
    bit          locked;
    bit          err;
    int          cnt;
    logic [15:0] pred;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$], qb[$];

  // Galois form of the generator polynomial: shift left, fold the top bit into taps 15, 2, 0.
  function automatic logic [15:0] nxt(input logic [15:0] q);
    return {q[14:0], 1'b0} ^ (q[15] ? 16'h8005 : 16'h0000);
  endfunction

  function automatic void mstep(inout mdl_t m, input int lock_n, input int loss_n, input int errw,
                                input bit v, input logic [15:0] d, input bit c, input bit r);
    int inc, maxv;
    m.err = 0;
    if (!r) begin
      m = '{mode: 0, pred: 16'h0, hits: 0, misses: 0, cnt: 0, err: 0};
      return;
    end
    maxv = (1 << errw) - 1;
`ifdef LFSR16_CHK_BITERR_EN
    inc = $countones(d ^ m.pred);
`else
    inc = 1;
`endif
    if (v) begin
      if (m.mode == 0) begin
        if (d != 0) begin m.pred = nxt(d); m.hits = 0; m.mode = 1; end
      end else if (m.mode == 1) begin
        if (d == m.pred) begin
          m.pred = nxt(d);
          m.hits++;
          if (m.hits == lock_n) begin m.mode = 2; m.misses = 0; end
        end else if (d != 0) begin
          m.pred = nxt(d); m.hits = 0;
        end else m.mode = 0;
      end else begin
        if (d == m.pred) m.misses = 0;
        else begin
          m.err = 1;
          m.cnt = (m.cnt + inc > maxv) ? maxv : m.cnt + inc;
          m.misses++;
          if (m.misses == loss_n) m.mode = 0;
        end
        m.pred = nxt(m.pred);
      end
    end
    if (c) m.cnt = 0;
  endfunction

  function automatic exp_t snap(input mdl_t m);
    exp_t e;
    e.locked = (m.mode == 2);
    e.err    = m.err;
    e.cnt    = m.cnt;
    e.pred   = m.pred;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Drive at negedge, model the edge, then return 2 time units after the posedge.
  task automatic drive(input bit v, input logic [15:0] d, input bit c, input bit r);
    @(negedge clk_in);
    valid_in = v; data_in = d; clear_in = c; rst_in = r;
    mstep(ma, 4, 3, 16, v, d, c, r);
    mstep(mb, 4, 31, 4, v, d, c, r);
    qa.push_back(snap(ma));
    qb.push_back(snap(mb));
    @(posedge clk_in);
    #2;
  endtask

  always @(posedge clk_in) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_locked", int'(locked_a), int'(e.locked));
      chk("a_error",  int'(error_a),  int'(e.err));
      chk("a_count",  int'(cnt_a),    e.cnt);
      chk("a_pred",   int'(exp_a),    int'(e.pred));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_locked", int'(locked_b), int'(e.locked));
      chk("b_error",  int'(error_b),  int'(e.err));
      chk("b_count",  int'(cnt_b),    e.cnt);
      chk("b_pred",   int'(exp_b),    int'(e.pred));
    end
  end

  task automatic lock_seq(input bit gaps);
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(1 << i), 0, 1);
      if (gaps) drive(0, 16'hFFFF, 0, 1);
    end
  endtask

  initial begin
    logic [15:0] gen;
    int          k;
    bit          v, c, r;
    logic [15:0] d;

    ma = '{mode: 0, pred: 16'h0, hits: 0, misses: 0, cnt: 0, err: 0};
    mb = ma;

    for (int i = 0; i < 3; i++) drive(0, 16'h0, 0, 0);
    chk("reset_locked", int'(locked_a), 0);
    chk("reset_pred",   int'(exp_a),    0);
    drive(0, 16'h0, 0, 1);

    lock_seq(0);
    chk("lock_locked", int'(locked_a), 1);
    chk("lock_count",  int'(cnt_a),    0);
    chk("lock_pred",   int'(exp_a),    16'h0020);

    drive(0, 16'h0, 0, 0);
    drive(0, 16'h0, 0, 1);
    lock_seq(1);
    chk("gap_locked", int'(locked_a), 1);
    chk("gap_pred",   int'(exp_a),    16'h0020);

    drive(1, 16'h0021, 0, 1);
    chk("single_err_pulse", int'(error_a), 1);
    drive(1, 16'h0040, 0, 1);
    chk("single_err_count",  int'(cnt_a),    1);
    chk("single_err_locked", int'(locked_a), 1);
    for (int i = 7; i < 16; i++) drive(1, 16'(1 << i), 0, 1);
    chk("step_8000", int'(exp_a), 16'h8005);

    drive(0, 16'h0, 1, 1);
    chk("clear_count", int'(cnt_a), 0);
    for (int i = 0; i < 3; i++) drive(1, ma.pred ^ 16'h0001, 0, 1);
    chk("loss_locked", int'(locked_a), 0);
`ifndef LFSR16_CHK_BITERR_EN
    chk("loss_count", int'(cnt_a), 3);
`endif
    drive(1, 16'h0000, 0, 1);
    chk("zero_ignored", int'(locked_a), 0);

    lock_seq(0);
    chk("relock", int'(locked_a), 1);
    drive(1, ma.pred ^ 16'h0004, 1, 1);
    chk("clear_wins_count", int'(cnt_a),   0);
    chk("clear_wins_pulse", int'(error_a), 1);

    for (int i = 0; i < 20; i++) drive(1, mb.pred ^ 16'h0100, 0, 1);
    chk("sat_count",  int'(cnt_b),    15);
    chk("sat_locked", int'(locked_b), 1);

    #1 rst_in = 1'b0;
    #1;
    chk("async_rst_locked", int'(locked_b), 0);
    chk("async_rst_count",  int'(cnt_b),    0);
    chk("async_rst_pred",   int'(exp_b),    0);
    drive(0, 16'h0, 0, 0);
    drive(0, 16'h0, 0, 1);

    lock_seq(0);
    drive(0, 16'h0, 1, 1);
    drive(1, 16'h00FF, 0, 1);
`ifdef LFSR16_CHK_BITERR_EN
    chk("biterr_ff", int'(cnt_a), 7);
`else
    chk("biterr_ff", int'(cnt_a), 1);
`endif
    drive(1, 16'h0041, 0, 1);
`ifdef LFSR16_CHK_BITERR_EN
    chk("biterr_41", int'(cnt_a), 8);
`else
    chk("biterr_41", int'(cnt_a), 2);
`endif

    gen = 16'hACE1;
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 99) < 80);
      c = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 199) != 0);
      k = $urandom_range(0, 99);
      if (k < 70)      d = gen;
      else if (k < 80) d = gen ^ 16'(1 << $urandom_range(0, 15));
      else if (k < 85) d = 16'h0000;
      else if (k < 92) begin gen = 16'($urandom_range(1, 65535)); d = gen; end
      else             d = 16'($urandom);
      if (v) gen = nxt(gen);
      drive(v, d, c, r);
    end

    drive(0, 16'h0, 0, 1);
    drive(0, 16'h0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
